// File: rtl/operand_fetch.sv
// Operand fetch stage: latches an RV32 instruction, waits on a register scoreboard, reads both sources and emits an operand bundle.
// Optional macro OPFETCH_BYPASS_EN lets a same-cycle writeback unblock a waiting source.
module operand_fetch #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [31:0]          instr,
   output logic [4:0]           readReg1,
   output logic [4:0]           readReg2,
   input  logic [DATAWIDTH-1:0] readData1,
   input  logic [DATAWIDTH-1:0] readData2,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_reg,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [DATAWIDTH-1:0] op_a,
   output logic [DATAWIDTH-1:0] op_b,
   output logic [31:0]          op_instr,
   output logic                 stall
);

   typedef enum logic [1:0] {IDLE, CHECK, READ, VALID} state_t;

   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   state_t                 state_q, state_d;
   logic [31:0]            instr_q, instr_d;
   logic [31:0]            busy_q, busy_d;
   logic [DATAWIDTH-1:0]   op_a_q, op_a_d;
   logic [DATAWIDTH-1:0]   op_b_q, op_b_d;
   logic [31:0]            op_instr_q, op_instr_d;

   logic [31:0]            wb_clear;
   logic [31:0]            busy_chk;
   logic                   blocked;
   logic                   writes_rd;

   assign readReg1    = instr_q[19:15];
   assign readReg2    = instr_q[24:20];
   assign instr_ready = (state_q == IDLE);
   assign op_valid    = (state_q == VALID);
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign op_instr    = op_instr_q;
   assign stall       = (state_q == CHECK) && blocked;

   always_comb begin
      wb_clear = 32'd0;
      if (wb_valid && (wb_reg != 5'd0)) wb_clear[wb_reg] = 1'b1;
`ifdef OPFETCH_BYPASS_EN
      busy_chk = busy_q & ~wb_clear;
`else
      busy_chk = busy_q;
`endif
      blocked   = busy_chk[instr_q[19:15]] | busy_chk[instr_q[24:20]];
      writes_rd = (instr_q[6:0] != OPC_STORE) && (instr_q[6:0] != OPC_BRANCH) &&
                  (instr_q[11:7] != 5'd0);
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_instr_d = op_instr_q;
      busy_d     = busy_q & ~wb_clear;
      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!blocked) state_d = READ;
         end
         READ: begin
            op_a_d     = readData1;
            op_b_d     = readData2;
            op_instr_d = instr_q;
            // Applied after the writeback clear so a same-edge set of this rd wins.
            if (writes_rd) busy_d[instr_q[11:7]] = 1'b1;
            state_d    = VALID;
         end
         VALID: begin
            if (op_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         instr_q    <= 32'd0;
         busy_q     <= 32'd0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_instr_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         busy_q     <= busy_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_instr_q <= op_instr_d;
      end
   end

endmodule
